// File: rtl/sar_pkg.sv
// Shared constants and types for the SAR capture / averaging path.
package sar_pkg;

    localparam int SAR_BITS       = 8;
    localparam int AVG_LOG2_MAX   = 4;
    localparam int FIFO_DEPTH_MAX = 16;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } avg_state_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sar_sample_fifo.sv
// DEPTH x 8-bit synchronous FIFO with occupancy count and drop indication.
// Latency: a push is visible at the head the cycle after it is written; head read is combinational.
// Backpressure: a push while full is dropped (drop=1) unless a pop happens in the same cycle.
module sar_sample_fifo
    import sar_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      core_clk,
    input  logic                      rst_n,
    input  logic                      push_vld,
    input  logic [SAR_BITS-1:0]       push_dat,
    input  logic                      pop_rdy,
    output logic                      pop_vld,
    output logic [SAR_BITS-1:0]       pop_dat,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [SAR_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count_q;
    logic                full;
    logic                empty;
    logic                pop;
    logic                push_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign pop     = pop_rdy & ~empty;
    // A pop frees the slot in the same edge, so a push into a full FIFO still lands.
    assign push_ok = push_vld & (~full | pop);
    assign drop    = push_vld & full & ~pop;

    assign pop_vld = ~empty;
    assign pop_dat = empty ? '0 : mem[rd_ptr];
    assign count   = count_q;

    always_ff @(posedge core_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge core_clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sar_avg_fifo.sv
// Captures SAR codes on each CKO rising edge, averages 2^AVG_LOG2 of them, buffers results.
// Latency: result pushed 2 CLK edges after CKO is first sampled high; visible the same cycle.
// Backpressure: valid/ready read port; a result arriving at a full FIFO is dropped and OVF set.
module sar_avg_fifo
    import sar_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int DEPTH    = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    EN,
    input  logic                    CKO,
    input  logic [0:7]              DATA,
    input  logic                    OUT_READY,
    output logic                    OUT_VALID,
    output logic [7:0]              OUT_DATA,
    output logic [$clog2(DEPTH):0]  COUNT,
    output logic                    OVF,
    input  logic                    CLR_OVF
);

    if (AVG_LOG2 < 0 || AVG_LOG2 > AVG_LOG2_MAX ||
        DEPTH < 2 || DEPTH > FIFO_DEPTH_MAX || !is_pow2(DEPTH)) begin : g_param_check
        $error("sar_avg_fifo: AVG_LOG2 or DEPTH out of legal range");
    end

    localparam int ACC_W = SAR_BITS + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic                cko_s1;
    logic                cko_s2;
    logic                cko_s3;
    logic [SAR_BITS-1:0] data_s1;
    logic [SAR_BITS-1:0] data_s2;
    logic                cap;

    avg_state_t          state;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;
    logic [ACC_W-1:0]    sum;
    logic                res_vld;
    logic [SAR_BITS-1:0] res_dat;
    logic                drop;

    // DATA[0] is the MSB; the positional copy lands it on bit 7.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cko_s1  <= 1'b0;
            cko_s2  <= 1'b0;
            cko_s3  <= 1'b0;
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            cko_s1  <= CKO;
            cko_s2  <= cko_s1;
            cko_s3  <= cko_s2;
            data_s1 <= DATA;
            data_s2 <= data_s1;
        end
    end

    assign cap     = cko_s2 & ~cko_s3 & EN;
    assign sum     = acc + ACC_W'(data_s2);
    assign res_vld = cap & (state == ACC) & (cnt == CNT_LAST);
    assign res_dat = SAR_BITS'(sum >> AVG_LOG2);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    acc <= '0;
                    cnt <= '0;
                    if (EN) begin
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (!EN) begin
                        // Partial window is abandoned; nothing is pushed.
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                    end else if (cap) begin
                        if (cnt == CNT_LAST) begin
                            acc <= '0;
                            cnt <= '0;
                        end else begin
                            acc <= sum;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    acc   <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    sar_sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .core_clk (CLK),
        .rst_n    (RST_N),
        .push_vld (res_vld),
        .push_dat (res_dat),
        .pop_rdy  (OUT_READY),
        .pop_vld  (OUT_VALID),
        .pop_dat  (OUT_DATA),
        .count    (COUNT),
        .drop     (drop)
    );

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            OVF <= 1'b0;
        end else if (drop) begin
            OVF <= 1'b1;
        end else if (CLR_OVF) begin
            OVF <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sar_avg_fifo.sv
// Scoreboard bench: pass-through (AVG_LOG2=0) and 4-sample averaging (AVG_LOG2=2) instances share stimulus.
module tb_sar_avg_fifo;

    logic       clk = 1'b0;
    logic       rst_n, en, cko, rdy, clr;
    logic [0:7] data;
    logic       v0, o0, v2, o2;
    logic [7:0] d0, d2;
    logic [2:0] c0, c2;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] q0[$];
    logic [7:0] q2[$];
    int         win_sum = 0;
    int         win_n = 0;
    bit         rand_rdy = 1'b0;

    always #5 clk = ~clk;

    sar_avg_fifo #(.AVG_LOG2(0), .DEPTH(4)) u_avg0 (
        .CLK(clk), .RST_N(rst_n), .EN(en), .CKO(cko), .DATA(data),
        .OUT_READY(rdy), .OUT_VALID(v0), .OUT_DATA(d0), .COUNT(c0),
        .OVF(o0), .CLR_OVF(clr)
    );

    sar_avg_fifo #(.AVG_LOG2(2), .DEPTH(4)) u_avg2 (
        .CLK(clk), .RST_N(rst_n), .EN(en), .CKO(cko), .DATA(data),
        .OUT_READY(rdy), .OUT_VALID(v2), .OUT_DATA(d2), .COUNT(c2),
        .OVF(o2), .CLR_OVF(clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: every accepted head entry must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && v0 && rdy) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain0: unexpected output %0h, expected none", d0);
            end else begin
                chk("drain0", d0, q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && v2 && rdy) begin
            if (q2.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain2: unexpected output %0h, expected none", d2);
            end else begin
                chk("drain2", d2, q2.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Reference: every enabled conversion is one sample; averager emits floor(sum of 4 / 4).
    task automatic model_conv(input logic [7:0] v, input bit drop0);
        if (!en) return;
        if (!drop0) q0.push_back(v);
        win_sum += v;
        win_n++;
        if (win_n == 4) begin
            q2.push_back(8'(win_sum / 4));
            win_sum = 0;
            win_n = 0;
        end
    endtask

    task automatic conv(input logic [7:0] v, input bit drop0);
        model_conv(v, drop0);
        cko  = 1'b1;
        data = v;
        ticks(3);
        cko  = 1'b0;
        data = 8'($urandom);
        ticks(3);
    endtask

    task automatic en_toggle();
        en = 1'b0;
        win_sum = 0;
        win_n = 0;
        ticks(3);
        en = 1'b1;
        ticks(3);
    endtask

    task automatic drain(input int n);
        rdy = 1'b1;
        ticks(n);
        rdy = 1'b0;
    endtask

    logic [7:0] s;

    initial begin
        rst_n = 1'b0; en = 1'b0; cko = 1'b0; data = '0; rdy = 1'b0; clr = 1'b0;
        ticks(3);
        chk("rst_valid0", v0, 0); chk("rst_data0", d0, 0);
        chk("rst_count0", c0, 0); chk("rst_ovf0", o0, 0);
        chk("rst_valid2", v2, 0); chk("rst_count2", c2, 0);
        rst_n = 1'b1;
        en = 1'b1;
        ticks(3);

        // Pass-through latency: CKO first sampled at edge t, visible after t+2.
        model_conv(8'hA5, 1'b0);
        cko = 1'b1; data = 8'hA5;
        tick();
        chk("lat_t0_valid", v0, 0);
        tick();
        chk("lat_t1_valid", v0, 0);
        tick();
        chk("lat_t2_valid", v0, 1);
        chk("lat_t2_data", d0, 8'hA5);
        chk("lat_t2_count", c0, 1);
        cko = 1'b0;
        ticks(3);
        chk("hold_data", d0, 8'hA5);
        drain(4);
        en_toggle();

        // Four-sample average 10,11,12,14 -> 11.
        conv(8'd10, 0); conv(8'd11, 0); conv(8'd12, 0);
        chk("avg_none_valid", v2, 0);
        chk("avg_none_count", c2, 0);
        conv(8'd14, 0);
        chk("avg_one_count", c2, 1);
        chk("avg_one_data", d2, 8'd11);
        chk("full_count0", c0, 4);
        chk("full_noovf0", o0, 0);
        drain(8);

        // Overflow: fifth conversion into a full FIFO is dropped.
        for (int i = 0; i < 5; i++) conv(8'($urandom), i == 4);
        chk("ovf_count", c0, 4);
        chk("ovf_set", o0, 1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("ovf_clr", o0, 0);
        drain(8);
        en_toggle();

        // Full FIFO popped in exactly the cycle of a new push.
        for (int i = 0; i < 4; i++) conv(8'($urandom), 0);
        s = 8'($urandom);
        model_conv(s, 1'b0);
        cko = 1'b1; data = s;
        ticks(2);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("pp_count", c0, 4);
        chk("pp_noovf", o0, 0);
        cko = 1'b0;
        ticks(3);
        drain(8);
        en_toggle();

        // EN drop discards the partial window.
        rdy = 1'b1;
        conv(8'h80, 0); conv(8'hF0, 0);
        en_toggle();
        for (int i = 0; i < 4; i++) conv(8'h20, 0);
        ticks(4);
        rdy = 1'b0;

        // Synchronous reset with entries pending.
        for (int i = 0; i < 3; i++) conv(8'($urandom), 0);
        chk("pre_rst_count", c0, 3);
        rst_n = 1'b0;
        tick();
        chk("srst_valid0", v0, 0); chk("srst_data0", d0, 0);
        chk("srst_count0", c0, 0); chk("srst_ovf0", o0, 0);
        chk("srst_count2", c2, 0);
        q0.delete(); q2.delete(); win_sum = 0; win_n = 0;
        rst_n = 1'b1;
        ticks(3);

        // Long CKO high plus an unsampled glitch low yields a single capture.
        s = 8'($urandom);
        model_conv(s, 1'b0);
        cko = 1'b1; data = s;
        ticks(20);
        #2 cko = 1'b0;
        #2 cko = 1'b1;
        ticks(5);
        cko = 1'b0;
        ticks(3);
        chk("long_count0", c0, 1);
        drain(4);
        en_toggle();

        // Randomized traffic with random consumer stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 48; i++) begin
            if (q0.size() >= 3) begin
                rand_rdy = 1'b0;
                rdy = 1'b1;
                ticks(4);
                rand_rdy = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) en_toggle();
            conv(8'($urandom), 0);
        end
        rand_rdy = 1'b0;
        rdy = 1'b1;
        ticks(10);
        chk("end_q0_empty", q0.size(), 0);
        chk("end_q2_empty", q2.size(), 0);
        chk("end_count0", c0, 0);
        chk("end_ovf0", o0, 0);
        chk("end_ovf2", o2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
